times_table_sweeper: RTL
========================

Name: times_table_sweeper

Overview:
- Upstream driver and result checker for the memory-based 0..7 x 0..7 multiplier.
- On start, walks all 64 operand pairs and drives the multiplier's a, b and read inputs.
- Compares each returned result against a locally computed a*b and reports mismatch count, first failing address and done.
- Used as a built-in self-test of the times-table memory contents.

Parameters:
- READ_LAT, 1, clock cycles from read/address presented to result valid at the multiplier output (1..4).
- RES_W, 6, width of the multiplier result bus; the expected product is truncated to RES_W bits before compare.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
- hold  input  1  while high, no new read is issued; in-flight results still return and are checked.
- a  output  3  operand a to the multiplier.
- b  output  3  operand b to the multiplier.
- read  output  1  read enable to the multiplier.
- result  input  RES_W  multiplier result, valid READ_LAT cycles after read.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; held until start or rst.
- err_count  output  7  number of mismatches in the current or last sweep (0..64).
- err_flag  output  1  high when err_count != 0.
- first_err_addr  output  6  address {a,b} of the first mismatch; 0 if none.

Behaviour:
- Address convention: addr = {a,b} = a*8 + b. Sweep order: addr 0..63, so b is the fast index.
- Reset: state=IDLE; a=0, b=0, read=0, busy=0, done=0, err_count=0, err_flag=0, first_err_addr=0. The pipeline valid bits are cleared.
- Reset mid-sweep aborts immediately with the same values. Results returned after reset are ignored.
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE with start=1 -> RUN. Clears err_count, err_flag, first_err_addr, done and the address counter.
  - RUN: each cycle with hold=0, read=1 and a,b=counter, then the counter increments. With hold=1, read=0 and the counter is frozen.
  - RUN, issuing addr 63 -> DRAIN.
  - DRAIN: read=0. Moves to DONE once every check-pipe valid bit is clear.
  - DONE: done=1, outputs static.
- start while busy is ignored. start and hold asserted together starts the sweep with no read until hold drops.
- Check pipe: a READ_LAT-deep shift register of {valid, addr}.
  - valid is loaded with read.
  - At the pipe output, when valid: expected = a*b (6-bit), compared with result over the low RES_W bits.
  - On mismatch: err_count increments. If err_count was 0, first_err_addr is loaded.
  - err_count is 7-bit and cannot exceed 64, so no saturation logic is needed.
- Timing with hold=0: start sampled at edge E0, addr 0 presented from E0. The last result is checked at E(64+READ_LAT), and done is high from that edge. busy is high for 64+READ_LAT cycles.
- a, b and read are registered outputs. err_flag is registered alongside err_count.

Decomposition:
- Shared package tt_pkg: ADDR_W=6, OP_W=3, TT_ENTRIES=64, and the state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, tt_check_pipe: the parameterised READ_LAT delay line of {valid, addr}.
- The FSM, counter and comparator stay in the top.

Test Plan:
- Correct memory model, READ_LAT=1, start pulse -> read high exactly 64 cycles; a,b go 0,0 .. 7,7; done at start+65; err_count=0, err_flag=0.
- Model corrupts addr 29 (3x5) to 0 -> err_count=1, err_flag=1, first_err_addr=29.
- Corrupt addrs 10 and 63 -> err_count=2, first_err_addr=10.
- hold high for 5 cycles after addr 20 -> read low for those 5 cycles; sweep resumes at addr 21; done 5 cycles later; err_count=0.
- rst at the cycle addr 40 is issued -> the next cycle shows IDLE with all outputs 0. A later start runs a full clean sweep with no stale errors.
- READ_LAT=3 with a second start pulse during RUN -> the pulse is ignored; done at start+67; err_count=0.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared constants, state encoding and product helper for the times-table sweeper.
package tt_pkg;

    localparam int ADDR_W     = 6;
    localparam int OP_W       = 3;
    localparam int TT_ENTRIES = 64;
    localparam int CNT_W      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reference product for an address {a,b}; 3x3-bit operands fit in 6 bits.
    function automatic logic [ADDR_W-1:0] tt_product(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] op_a;
        logic [ADDR_W-1:0] op_b;
        op_a = ADDR_W'(addr[ADDR_W-1:OP_W]);
        op_b = ADDR_W'(addr[OP_W-1:0]);
        return op_a * op_b;
    endfunction

endpackage

// File: rtl/tt_check_pipe.sv
// Delay line of {valid, addr} that lines up each issued read with its returning result.
module tt_check_pipe
    import tt_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy
);

    logic [LAT-1:0]    r_valid;
    logic [ADDR_W-1:0] r_addr [LAT];
    logic [LAT-1:0]    w_inner_mask;

    // Shift stage: valid bits are cleared on reset, addresses simply follow along.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
        r_addr[0] <= i_addr;
        for (int i = 1; i < LAT; i++) begin
            r_addr[i] <= r_addr[i-1];
        end
    end

    // Every stage except the last; the last stage is consumed on the edge that
    // also decides whether the drain is complete.
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_inner
            if (gi < LAT - 1) begin : g_mid
                assign w_inner_mask[gi] = r_valid[gi];
            end else begin : g_last
                assign w_inner_mask[gi] = 1'b0;
            end
        end
    endgenerate

    assign o_valid = r_valid[LAT-1];
    assign o_addr  = r_addr[LAT-1];
    assign o_busy  = |w_inner_mask;

endmodule

// File: rtl/times_table_sweeper.sv
// Walks all 64 operand pairs of the memory multiplier and checks every returned product.
module times_table_sweeper
    import tt_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int RES_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [OP_W-1:0]   a,
    output logic [OP_W-1:0]   b,
    output logic              read,
    input  logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_start_ok;

    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic              r_read;

    logic [CNT_W-1:0]  r_err_count;
    logic              r_err_flag;
    logic [ADDR_W-1:0] r_first_err_addr;

    logic              w_chk_valid;
    logic [ADDR_W-1:0] w_chk_addr;
    logic              w_pipe_busy;
    logic [RES_W-1:0]  w_expected;
    logic              w_mismatch;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    // State register and address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and read-issue decisions.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_issue      = 1'b0;
        w_issue_addr = r_cnt;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                    // Address 0 goes out on the same edge that accepts start.
                    if (!hold) begin
                        w_issue      = 1'b1;
                        w_issue_addr = '0;
                        w_cnt_next   = ADDR_W'(1);
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    w_issue    = 1'b1;
                    w_cnt_next = r_cnt + ADDR_W'(1);
                    if (r_cnt == ADDR_W'(TT_ENTRIES - 1)) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish on the edge that checks the last outstanding result,
                // i.e. when nothing will remain in the pipe after this shift.
                if (!r_read && !w_pipe_busy) begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered multiplier interface; a,b keep their last value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_read <= 1'b0;
        end else begin
            r_read <= w_issue;
            if (w_issue) begin
                r_a <= w_issue_addr[ADDR_W-1:OP_W];
                r_b <= w_issue_addr[OP_W-1:0];
            end
        end
    end

    tt_check_pipe #(
        .LAT (READ_LAT)
    ) u_check_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_read),
        .i_addr  ({r_a, r_b}),
        .o_valid (w_chk_valid),
        .o_addr  (w_chk_addr),
        .o_busy  (w_pipe_busy)
    );

    assign w_expected = RES_W'(tt_product(w_chk_addr));
    assign w_mismatch = w_chk_valid && (result != w_expected);

    // Error bookkeeping: cleared by an accepted start, bumped on each mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count      <= '0;
            r_err_flag       <= 1'b0;
            r_first_err_addr <= '0;
        end else if (w_start_ok) begin
            r_err_count      <= '0;
            r_err_flag       <= 1'b0;
            r_first_err_addr <= '0;
        end else if (w_mismatch) begin
            r_err_count <= r_err_count + CNT_W'(1);
            r_err_flag  <= 1'b1;
            if (r_err_count == '0) begin
                r_first_err_addr <= w_chk_addr;
            end
        end
    end

    assign a              = r_a;
    assign b              = r_b;
    assign read           = r_read;
    assign busy           = (r_state == RUN) || (r_state == DRAIN);
    assign done           = (r_state == DONE);
    assign err_count      = r_err_count;
    assign err_flag       = r_err_flag;
    assign first_err_addr = r_first_err_addr;

endmodule
